// File: rtl/gfx_pkg.sv
// Shared framebuffer constants, engine state encoding and pixel address helper.
package gfx_pkg;
    localparam int SCREEN_W_DEF = 320;
    localparam int SCREEN_H_DEF = 200;
    localparam int ADDR_W       = 16;
    localparam int XW           = 9;
    localparam int YW           = 8;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        BLIT_RD,
        BLIT_WAIT,
        BLIT_WR
    } state_e;

    // Linear framebuffer address y*w + x, truncated to the bus width.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [XW:0] x,
                                                   input logic [YW:0] y,
                                                   input int unsigned w);
        return ADDR_W'(32'(y) * w + 32'(x));
    endfunction
endpackage

// File: rtl/blit_fill_engine_if.sv
// 1-bit-per-pixel framebuffer port between the engine (master) and memory (slave).
interface blit_fill_engine_if;
    import gfx_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic              mem_wdata;
    logic              mem_rdata;

    modport master (output mem_addr, mem_re, mem_we, mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, mem_re, mem_we, mem_wdata, output mem_rdata);
endinterface

// File: rtl/rect_scanner.sv
// Walks pixel offsets over a w x h rectangle, x fastest, forward or backward,
// flagging the final pixel of the walk.
module rect_scanner
    import gfx_pkg::*;
#(
    parameter int SXW = XW,
    parameter int SYW = YW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic           fwd_in,
    input  logic [SXW-1:0] w_in,
    input  logic [SYW-1:0] h_in,
    output logic [SXW-1:0] dx,
    output logic [SYW-1:0] dy,
    output logic           last,
    output logic           empty
);
    logic [SXW-1:0] w_q, w_d, dx_q, dx_d;
    logic [SYW-1:0] h_q, h_d, dy_q, dy_d;
    logic           fwd_q, fwd_d;

    assign dx    = dx_q;
    assign dy    = dy_q;
    assign empty = (w_q == '0) || (h_q == '0);
    assign last  = fwd_q ? ((dx_q == w_q - SXW'(1)) && (dy_q == h_q - SYW'(1)))
                         : ((dx_q == '0) && (dy_q == '0));

    always_comb begin
        w_d   = w_q;
        h_d   = h_q;
        fwd_d = fwd_q;
        dx_d  = dx_q;
        dy_d  = dy_q;
        if (load) begin
            w_d   = w_in;
            h_d   = h_in;
            fwd_d = fwd_in;
            dx_d  = fwd_in ? '0 : w_in - SXW'(1);
            dy_d  = fwd_in ? '0 : h_in - SYW'(1);
        end else if (step && !last && !empty) begin
            if (fwd_q) begin
                if (dx_q == w_q - SXW'(1)) begin
                    dx_d = '0;
                    dy_d = dy_q + SYW'(1);
                end else begin
                    dx_d = dx_q + SXW'(1);
                end
            end else begin
                if (dx_q == '0) begin
                    dx_d = w_q - SXW'(1);
                    dy_d = dy_q - SYW'(1);
                end else begin
                    dx_d = dx_q - SXW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q   <= '0;
            h_q   <= '0;
            fwd_q <= 1'b0;
            dx_q  <= '0;
            dy_q  <= '0;
        end else begin
            w_q   <= w_d;
            h_q   <= h_d;
            fwd_q <= fwd_d;
            dx_q  <= dx_d;
            dy_q  <= dy_d;
        end
    end
endmodule

// File: rtl/blit_fill_engine.sv
// Rectangle fill and overlap-safe blit over a 1-bpp framebuffer; one shared
// rect_scanner supplies pixel offsets for both operations.
module blit_fill_engine
    import gfx_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [8:0]          x1,
    input  logic [7:0]          y1,
    input  logic [8:0]          x2,
    input  logic [7:0]          y2,
    input  logic [8:0]          op_width,
    input  logic [7:0]          op_height,
    input  logic                start_blit,
    input  logic                start_fill,
    input  logic                fill_value,
    output logic                busy,
    blit_fill_engine_if.master  mem
);
    localparam logic [9:0] SW10 = 10'(SCREEN_W);
    localparam logic [8:0] SH9  = 9'(SCREEN_H);

    state_e      state_q, state_d;
    logic [8:0]  x1_q, x1_d, x2_q, x2_d;
    logic [7:0]  y1_q, y1_d, y2_q, y2_d;
    logic        fill_q, fill_d, pix_q, pix_d;

    logic        sc_load, sc_step, sc_fwd, sc_last, sc_empty;
    logic [8:0]  sc_w, sc_dx;
    logic [7:0]  sc_h, sc_dy;

    logic [9:0]  x2c, xmax, wlim;
    logic [8:0]  y2c, ymax, hlim;
    logic [8:0]  fill_w, blit_w;
    logic [7:0]  fill_h, blit_h;
    logic        blit_fwd;

    logic [ADDR_W-1:0] src_addr, dst_addr, addr_c;
    logic              re_c, we_c, wdata_c;

    // Operation size from the raw inputs; only meaningful on the accept cycle.
    always_comb begin
        x2c    = (10'(x2) > SW10) ? SW10 : 10'(x2);
        fill_w = (x2c > 10'(x1)) ? 9'(x2c - 10'(x1)) : '0;
        y2c    = (9'(y2) > SH9) ? SH9 : 9'(y2);
        fill_h = (y2c > 9'(y1)) ? 8'(y2c - 9'(y1)) : '0;

        xmax   = (x1 > x2) ? 10'(x1) : 10'(x2);
        wlim   = (xmax < SW10) ? SW10 - xmax : '0;
        blit_w = (10'(op_width) < wlim) ? op_width : 9'(wlim);
        ymax   = (y1 > y2) ? 9'(y1) : 9'(y2);
        hlim   = (ymax < SH9) ? SH9 - ymax : '0;
        blit_h = (9'(op_height) < hlim) ? op_height : 8'(hlim);

        // Destination above/left of source copies forward; otherwise backward.
        blit_fwd = (y2 < y1) || ((y2 == y1) && (x2 <= x1));
    end

    rect_scanner #(.SXW(9), .SYW(8)) u_scan (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (sc_load),
        .step   (sc_step),
        .fwd_in (sc_fwd),
        .w_in   (sc_w),
        .h_in   (sc_h),
        .dx     (sc_dx),
        .dy     (sc_dy),
        .last   (sc_last),
        .empty  (sc_empty)
    );

    assign src_addr = pix_addr({1'b0, x1_q} + {1'b0, sc_dx}, {1'b0, y1_q} + {1'b0, sc_dy}, SCREEN_W);
    assign dst_addr = pix_addr({1'b0, x2_q} + {1'b0, sc_dx}, {1'b0, y2_q} + {1'b0, sc_dy}, SCREEN_W);

    always_comb begin
        state_d = state_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        x2_d    = x2_q;
        y2_d    = y2_q;
        fill_d  = fill_q;
        pix_d   = pix_q;
        sc_load = 1'b0;
        sc_step = 1'b0;
        sc_fwd  = 1'b1;
        sc_w    = fill_w;
        sc_h    = fill_h;
        re_c    = 1'b0;
        we_c    = 1'b0;
        wdata_c = 1'b0;
        addr_c  = src_addr;
        case (state_q)
            IDLE: begin
                if (start_blit || start_fill) begin
                    x1_d    = x1;
                    y1_d    = y1;
                    x2_d    = x2;
                    y2_d    = y2;
                    fill_d  = fill_value;
                    sc_load = 1'b1;
                    state_d = FILL;
                    if (start_blit) begin
                        sc_w   = blit_w;
                        sc_h   = blit_h;
                        sc_fwd = blit_fwd;
                        // An empty blit borrows FILL's single no-write cycle.
                        if ((blit_w != '0) && (blit_h != '0)) state_d = BLIT_RD;
                    end
                end
            end
            FILL: begin
                we_c    = !sc_empty;
                wdata_c = fill_q;
                sc_step = 1'b1;
                if (sc_empty || sc_last) state_d = IDLE;
            end
            BLIT_RD: begin
                re_c    = 1'b1;
                state_d = BLIT_WAIT;
            end
            BLIT_WAIT: begin
                pix_d   = mem.mem_rdata;
                state_d = BLIT_WR;
            end
            BLIT_WR: begin
                we_c    = 1'b1;
                addr_c  = dst_addr;
                wdata_c = pix_q;
                sc_step = 1'b1;
                state_d = sc_last ? IDLE : BLIT_RD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x1_q    <= '0;
            y1_q    <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            fill_q  <= 1'b0;
            pix_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            x2_q    <= x2_d;
            y2_q    <= y2_d;
            fill_q  <= fill_d;
            pix_q   <= pix_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign mem.mem_addr  = addr_c;
    assign mem.mem_re    = re_c;
    assign mem.mem_we    = we_c;
    assign mem.mem_wdata = wdata_c;
endmodule

// File: doc/blit_fill_engine.md
BLIT_FILL_ENGINE -- requirements
Module: blit_fill_engine

Interface
REQ-001 SHALL have parameter SCREEN_W, default 320, meaning framebuffer width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 200, meaning framebuffer height in pixels.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports x1 in 9, y1 in 8  fill corner A / blit source top-left.
REQ-006 SHALL have ports x2 in 9, y2 in 8  fill corner B (exclusive) / blit destination top-left.
REQ-007 SHALL have ports op_width in 9, op_height in 8  blit size in pixels.
REQ-008 SHALL have ports start_blit in 1, start_fill in 1, fill_value in 1  one-cycle command pulses plus fill colour.
REQ-009 SHALL have port busy  out  1  operation in progress.
REQ-010 SHALL have ports mem_addr out 16, mem_re out 1, mem_we out 1, mem_wdata out 1, mem_rdata in 1  1-bit-per-pixel framebuffer port, address = y*SCREEN_W + x.

Function
REQ-011 SHALL implement states IDLE, FILL, BLIT_RD, BLIT_WAIT, BLIT_WR.
REQ-012 SHALL, in IDLE, latch x1,y1,x2,y2,op_width,op_height,fill_value on the cycle a start pulse is high.
REQ-013 SHALL give start_blit priority when start_blit and start_fill are high together.
REQ-014 SHALL ignore start pulses while busy is 1.
REQ-015 SHALL clamp fill bounds to x2'=min(x2,SCREEN_W), y2'=min(y2,SCREEN_H); fill covers x1<=x<x2', y1<=y<y2'.
REQ-016 SHALL clip blit width to min(op_width, SCREEN_W-max(x1,x2)) and height to min(op_height, SCREEN_H-max(y1,y2)); coordinates at or beyond the screen edge give zero size.
REQ-017 SHALL treat a zero-size operation as complete: busy high for exactly one cycle, no mem_re/mem_we.
REQ-018 SHALL, in FILL, write one pixel per cycle (mem_we=1, mem_wdata=latched fill_value), row-major, x fastest.
REQ-019 SHALL, in blit, spend 3 cycles per pixel: BLIT_RD (mem_re=1, source address), BLIT_WAIT (mem_rdata valid at end of this cycle, captured), BLIT_WR (mem_we=1, destination address, captured bit).
REQ-020 SHALL traverse blit forward (top-left to bottom-right) when y2<y1 or (y2==y1 and x2<=x1), else backward (bottom-right to top-left), so overlapping copies are correct.
REQ-021 SHALL assert busy the cycle after the accepted start pulse and drop it the cycle after the last write.
REQ-022 SHALL issue the first memory access in the first busy cycle.
REQ-023 SHALL hold mem_re=mem_we=0 and mem_addr stable in IDLE.
REQ-024 SHALL compute addresses as 16-bit y*SCREEN_W+x, with no wrap for in-range coordinates (max 63999).

Reset
REQ-025 SHALL, on rst_n low, go to IDLE immediately with busy=0, mem_re=0, mem_we=0, mem_wdata=0, mem_addr=0, all counters and latched parameters 0.
REQ-026 SHALL abort any operation on reset mid-run; pixels already written stay written, no further access.

Structure
REQ-027 SHALL put SCREEN_W/SCREEN_H defaults, state encoding and 16-bit address width in shared package gfx_pkg.
REQ-028 SHALL use one sub-module rect_scanner (x/y counters over a rectangle, forward/backward, last-pixel flag), instantiated once and shared by fill and blit.

Verification
REQ-029 SHALL cover full-screen fill: x1=0,y1=0,x2=320,y2=200,fill_value=1 -> 64000 writes, addresses 0..63999 in order, busy high 64000 cycles.
REQ-030 SHALL cover clipped fill: x1=310,y1=195,x2=400,y2=255,fill_value=0 -> 50 writes, first 62710, last 63999.
REQ-031 SHALL cover overlapping blit: source (0,0), destination (1,0), size 4x1, memory row 1,0,1,1 -> read/write backward, row becomes 1,1,0,1,1, 12 busy cycles.
REQ-032 SHALL cover forward blit: source (10,10), destination (0,0), size 2x2 -> reads 3210,3211,3530,3531, writes 0,1,320,321 in that order.
REQ-033 SHALL cover simultaneous start_blit+start_fill, and start_fill while busy -> blit runs, the other pulses are ignored.
REQ-034 SHALL cover rst_n low during cycle 100 of a full fill -> busy=0 and mem_we=0 immediately, exactly 99 writes recorded.
